// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// error codes and frame header field lengths.
package imem_loader_pkg;

    // Frame header field lengths in bytes (both little-endian on the wire).
    localparam int ADDR_BYTES = 4;
    localparam int CNT_BYTES  = 2;

    // Loader FSM states, in frame order.
    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_ADDR  = 3'd1,
        LD_COUNT = 3'd2,
        LD_DATA  = 3'd3,
        LD_CHK   = 3'd4,
        LD_DONE  = 3'd5,
        LD_ERR   = 3'd6
    } ld_state_t;

    // Value reported on the error output after a failed frame.
    typedef enum logic [1:0] {
        LD_ERR_NONE  = 2'd0,
        LD_ERR_ALIGN = 2'd1,
        LD_ERR_RANGE = 2'd2,
        LD_ERR_CSUM  = 2'd3
    } ld_err_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem byte-write port of the loader.
//
// Stream handshake: a byte moves from source to loader on every rising clk
// edge where in_valid and in_ready are both 1. The source holds in_data
// stable while in_valid is 1 and not yet accepted; in_ready depends only on
// loader state, never on in_valid. Bytes offered while in_ready is 0 are not
// consumed.
//
// Write port: wr_en is a one-cycle strobe; wr_addr/wr_data are valid while
// wr_en is 1. There is no back-pressure on the write side.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // Byte source / imem side.
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed little-endian byte stream (ADDR, COUNT, data, CHK) into the
// byte-addressed instruction memory, holding the fetch stage until a frame
// completes with a matching checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 65536,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] entry_pc,
    output logic              done,
    output logic [1:0]        error,
    output ld_state_t         dbg_state
);

    // Range check is done wide enough that addr + 4*COUNT can never wrap.
    localparam int SUM_W   = ADDR_W + CNT_W + 2;
    localparam int FIELD_W = 8 * ADDR_BYTES;

    ld_state_t state, state_next;

    // Header fields arrive LSB first and are shifted in from the top, so the
    // completed field ends up in the upper bytes of field_sr. ADDR and COUNT
    // share this shift register and byte counter.
    logic [FIELD_W-1:0] field_sr;
    logic [FIELD_W-1:0] field_next;
    logic [1:0]         field_cnt;
    logic               field_last;
    logic [ADDR_W-1:0]  addr_field;
    logic [CNT_W-1:0]   cnt_field;

    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W+1:0]   data_left;
    logic [CNT_W+1:0]   left_one;
    logic [7:0]         csum;
    logic [SUM_W-1:0]   frame_end;
    logic               range_bad;
    logic               xfer;

    logic               begin_frame;
    logic               set_done;
    logic               set_err;
    ld_err_t            err_code;

    assign bus.in_ready = (state == LD_ADDR) || (state == LD_COUNT) ||
                          (state == LD_DATA) || (state == LD_CHK);
    assign xfer         = bus.in_valid & bus.in_ready;
    assign dbg_state    = state;

    assign field_next = {bus.in_data, field_sr[FIELD_W-1:8]};
    assign addr_field = ADDR_W'(field_next);
    assign cnt_field  = CNT_W'(field_next[FIELD_W-1 -: 8*CNT_BYTES]);
    assign field_last = (state == LD_ADDR) ? (field_cnt == 2'(ADDR_BYTES - 1))
                                           : (field_cnt == 2'(CNT_BYTES - 1));

    assign frame_end = SUM_W'(addr_reg) + SUM_W'({cnt_field, 2'b00});
    assign range_bad = frame_end > SUM_W'(MEM_BYTES);
    assign left_one  = {{(CNT_W+1){1'b0}}, 1'b1};

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus one-cycle strobes for the datapath.
    always_comb begin
        state_next  = state;
        begin_frame = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        err_code    = LD_ERR_NONE;
        unique case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_next  = LD_ADDR;
                    begin_frame = 1'b1;
                end
            end
            LD_ADDR: begin
                if (xfer && field_last) begin
                    if (addr_field[1:0] != 2'b00) begin
                        state_next = LD_ERR;
                        set_err    = 1'b1;
                        err_code   = LD_ERR_ALIGN;
                    end else begin
                        state_next = LD_COUNT;
                    end
                end
            end
            LD_COUNT: begin
                if (xfer && field_last) begin
                    if (range_bad) begin
                        state_next = LD_ERR;
                        set_err    = 1'b1;
                        err_code   = LD_ERR_RANGE;
                    end else if (cnt_field == '0) begin
                        state_next = LD_CHK;
                    end else begin
                        state_next = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (xfer && (data_left == left_one)) begin
                    state_next = LD_CHK;
                end
            end
            LD_CHK: begin
                if (xfer) begin
                    if (bus.in_data == csum) begin
                        state_next = LD_DONE;
                        set_done   = 1'b1;
                    end else begin
                        state_next = LD_ERR;
                        set_err    = 1'b1;
                        err_code   = LD_ERR_CSUM;
                    end
                end
            end
            default: begin
                state_next = LD_IDLE;
            end
        endcase
    end

    // Header capture, imem write pipeline register, checksum and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_sr    <= '0;
            field_cnt   <= '0;
            addr_reg    <= '0;
            ptr         <= '0;
            data_left   <= '0;
            csum        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            cpu_hold    <= 1'b1;
            entry_pc    <= '0;
            done        <= 1'b0;
            error       <= LD_ERR_NONE;
        end else begin
            bus.wr_en <= 1'b0;

            if (begin_frame) begin
                field_sr  <= '0;
                field_cnt <= '0;
                data_left <= '0;
                csum      <= '0;
                cpu_hold  <= 1'b1;
                done      <= 1'b0;
                error     <= LD_ERR_NONE;
            end

            if (xfer && ((state == LD_ADDR) || (state == LD_COUNT))) begin
                field_sr  <= field_next;
                field_cnt <= field_last ? 2'd0 : field_cnt + 2'd1;
            end

            if (xfer && (state == LD_ADDR) && field_last) begin
                addr_reg <= addr_field;
                ptr      <= addr_field;
            end

            if (xfer && (state == LD_COUNT) && field_last) begin
                data_left <= {cnt_field, 2'b00};
            end

            if (xfer && (state == LD_DATA)) begin
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= ptr;
                bus.wr_data <= bus.in_data;
                ptr         <= ptr + ADDR_W'(1);
                csum        <= csum ^ bus.in_data;
                data_left   <= data_left - left_one;
            end

            if (set_err) begin
                error <= err_code;
            end

            if (set_done) begin
                done     <= 1'b1;
                entry_pc <= addr_reg;
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a driver feeds frames byte by byte and
// queues the imem writes each data byte should cause; a monitor pops and
// compares whenever wr_en is seen.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cpu_hold;
    logic [ADDR_W-1:0] entry_pc;
    logic              done;
    logic [1:0]        error;
    ld_state_t         dbg_state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W(ADDR_W), .MEM_BYTES(65536), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
        .cpu_hold(cpu_hold), .entry_pc(entry_pc), .done(done),
        .error(error), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int                  total = 0;
    int                  bad = 0;
    logic [ADDR_W+7:0]   exp_q[$];
    logic [ADDR_W+7:0]   exp_w;
    logic [ADDR_W-1:0]   exp_ptr;
    logic [7:0]          chk;
    logic [7:0]          b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks (called at posedge+#1)
    task automatic send_byte(input logic [7:0] d, input bit is_data);
        int waited = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got in_ready=%b after %0d cycles expected 1", bus.in_ready, waited);
        end else begin
            if (is_data) begin
                exp_q.push_back({exp_ptr, d});
                exp_ptr = exp_ptr + 1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_le(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < n; i++) begin
            send_byte(t[7:0], 1'b0);
            t = t >> 8;
        end
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("wr_en_idle", bus.wr_en, 1'b0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Scoreboard monitor
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", bus.wr_addr, bus.wr_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("imem_write", {bus.wr_addr, bus.wr_data}, exp_w);
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_entry_pc", entry_pc, 0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 0);
        check("rst_state", dbg_state, LD_IDLE);
        rst = 1'b0;
        @(posedge clk); #1;

        // in_valid in IDLE is not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_consume", dbg_state, LD_IDLE);
        bus.in_valid = 1'b0;

        // 1: basic frame
        start_frame();
        check("t1_state_addr", dbg_state, LD_ADDR);
        check("t1_hold", cpu_hold, 1'b1);
        exp_ptr = 32'h4;
        send_le(32'h4, 4);
        send_le(32'h1, 2);
        send_byte(8'hB3, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hEC, 1'b0);
        check("t1_state", dbg_state, LD_DONE);
        check("t1_done", done, 1'b1);
        check("t1_entry_pc", entry_pc, 32'h4);
        check("t1_hold", cpu_hold, 1'b0);
        check("t1_error", error, 0);
        check("t1_writes_left", exp_q.size(), 0);

        // in_valid in DONE is not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        check("done_in_ready", bus.in_ready, 1'b0);
        check("done_no_consume", dbg_state, LD_DONE);
        bus.in_valid = 1'b0;

        // 2: misaligned address
        start_frame();
        check("t2_done_cleared", done, 1'b0);
        check("t2_hold_set", cpu_hold, 1'b1);
        send_le(32'h6, 4);
        check("t2_state", dbg_state, LD_ERR);
        check("t2_error", error, 1);
        check("t2_hold", cpu_hold, 1'b1);
        check("t2_entry_pc", entry_pc, 32'h4);

        // 3: out of range
        start_frame();
        check("t3_error_cleared", error, 0);
        send_le(32'hFFFC, 4);
        send_le(32'h2, 2);
        check("t3_state", dbg_state, LD_ERR);
        check("t3_error", error, 2);
        check("t3_done", done, 1'b0);

        // Exact fit ending at MEM_BYTES-1
        start_frame();
        exp_ptr = 32'hFFF8;
        send_le(32'hFFF8, 4);
        send_le(32'h2, 2);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
        send_byte(8'h88, 1'b0);
        check("fit_done", done, 1'b1);
        check("fit_entry_pc", entry_pc, 32'hFFF8);
        check("fit_error", error, 0);

        // 4: bad checksum
        start_frame();
        exp_ptr = 32'h100;
        send_le(32'h100, 4);
        send_le(32'h2, 2);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h04, 1'b1); send_byte(8'h08, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);
        send_byte(8'h40, 1'b1); send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b0);
        check("t4_state", dbg_state, LD_ERR);
        check("t4_error", error, 3);
        check("t4_done", done, 1'b0);
        check("t4_entry_pc", entry_pc, 32'hFFF8);
        check("t4_hold", cpu_hold, 1'b1);
        check("t4_writes_left", exp_q.size(), 0);

        // 5: random in_valid gaps during DATA, start ignored mid-frame
        start_frame();
        exp_ptr = 32'h20;
        send_le(32'h20, 4);
        send_le(32'h3, 2);
        chk = 8'h00;
        for (int i = 0; i < 12; i++) begin
            b = 8'(i * 8'h13 + 8'h07);
            chk = chk ^ b;
            gap($urandom_range(0, 2));
            if (i == 5) begin
                start_frame();
                check("t5_start_ignored", dbg_state, LD_DATA);
            end
            send_byte(b, 1'b1);
            check("t5_wr_en_after_xfer", bus.wr_en, 1'b1);
        end
        gap(1);
        send_byte(chk, 1'b0);
        check("t5_done", done, 1'b1);
        check("t5_entry_pc", entry_pc, 32'h20);

        // 6: reset mid-frame, then a clean frame
        start_frame();
        exp_ptr = 32'h40;
        send_le(32'h40, 4);
        send_le(32'h2, 2);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_wr_en", bus.wr_en, 1'b0);
        check("t6_wr_addr", bus.wr_addr, 0);
        check("t6_wr_data", bus.wr_data, 0);
        check("t6_in_ready", bus.in_ready, 1'b0);
        check("t6_hold", cpu_hold, 1'b1);
        check("t6_entry_pc", entry_pc, 0);
        check("t6_done", done, 1'b0);
        check("t6_error", error, 0);
        check("t6_state", dbg_state, LD_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_frame();
        exp_ptr = 32'h80;
        send_le(32'h80, 4);
        send_le(32'h1, 2);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b0);
        check("t6_reload_done", done, 1'b1);
        check("t6_reload_entry_pc", entry_pc, 32'h80);

        // COUNT=0: straight to CHK, expected checksum 0x00
        start_frame();
        send_le(32'h200, 4);
        send_le(32'h0, 2);
        check("cnt0_state_chk", dbg_state, LD_CHK);
        send_byte(8'h00, 1'b0);
        check("cnt0_done", done, 1'b1);
        check("cnt0_entry_pc", entry_pc, 32'h200);
        check("cnt0_hold", cpu_hold, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("final_writes_left", exp_q.size(), 0);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
